// File: rtl/dram_feature_wr_addr_pkg.sv
// Shared definitions for the DRAM feature write-address generator:
// FSM encoding, burst-length width and the 4KB-in-beats helper.
package dram_feature_wr_addr_pkg;

    localparam int unsigned LenW       = 8;
    localparam int unsigned FourkBytes = 4096;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StCalc,
        StLen,
        StIssue
    } state_e;

    function automatic int unsigned fourk_beats(input int unsigned axiwidth);
        return FourkBytes * 8 / axiwidth;
    endfunction

endpackage

// File: rtl/dram_feature_wr_addr_feature_row_fifo.sv
// Two-entry FIFO of completed output-row indices waiting for write-address bursts.
module feature_row_fifo #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt_q == 2'd2);
    assign empty    = (cnt_q == 2'd0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/dram_feature_wr_addr.sv
// Turns "output row ready" handshakes into write-address bursts for that row.
// Define DRAM_FEATURE_WR_4K_SPLIT_EN to keep every burst inside one 4KB page.
module dram_feature_wr_addr
    import dram_feature_wr_addr_pkg::*;
#(
    parameter int unsigned W_WIDTH    = 10,
    parameter int unsigned LITEWIDTH  = 32,
    parameter int unsigned DEPTHWIDTH = 9,
    parameter int unsigned AXIWIDTH   = 128,
    parameter int unsigned MAX_BURST  = 64
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_ap_start,
    input  logic [LITEWIDTH-1:0]  I_feature_out_base_addr,
    input  logic [DEPTHWIDTH-1:0] I_coMemGroup,
    input  logic [W_WIDTH-1:0]    I_owidth,
    input  logic [W_WIDTH-1:0]    I_oheight,
    input  logic                  I_row_valid,
    input  logic [W_WIDTH-1:0]    I_row_hindex,
    output logic                  O_row_rdy,
    output logic [LITEWIDTH-1:0]  O_dram_feature_wr_addr,
    output logic [LenW-1:0]       O_dram_feature_wr_len,
    output logic                  O_dram_feature_wr_valid,
    input  logic                  I_dram_feature_wr_rdy,
    output logic                  O_busy,
    output logic                  O_done
);

    localparam int unsigned LbW        = DEPTHWIDTH + W_WIDTH;
    localparam int unsigned FourkBeats = fourk_beats(AXIWIDTH);

    state_e               state_q;
    logic                 ap_q, ap_prev_q;
    logic [LITEWIDTH-1:0] base_q, addr_q;
    logic [W_WIDTH-1:0]   oheight_q, hindex_q, row_cnt_q;
    logic [LbW-1:0]       line_beats_q, remaining_q;
    logic [8:0]           len_q, len_next;
    logic [LenW-1:0]      wr_len_q;
    logic                 busy_q, done_q, valid_q;
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [W_WIDTH-1:0]   fifo_data;
    logic                 start, row_push, burst_hs, row_last, row_fin;
    logic [31:0]          cap;
`ifdef DRAM_FEATURE_WR_4K_SPLIT_EN
    logic [31:0]          room;
`endif

    assign start     = ap_q & ~ap_prev_q;
    assign O_row_rdy = busy_q & ~fifo_full;
    assign row_push  = I_row_valid & O_row_rdy;
    assign fifo_pop  = (state_q == StWait) & ~fifo_empty;
    assign burst_hs  = valid_q & I_dram_feature_wr_rdy;
    assign row_last  = ({1'b0, row_cnt_q} + {{W_WIDTH{1'b0}}, 1'b1}) == {1'b0, oheight_q};

    // A row finishes either on its last burst handshake or straight away when it has no beats.
    assign row_fin = ((state_q == StCalc) && (hindex_q < oheight_q) && (line_beats_q == '0)) ||
                     ((state_q == StIssue) && burst_hs && (remaining_q == LbW'(len_q)));

    always_comb begin
        cap = 32'(MAX_BURST);
`ifdef DRAM_FEATURE_WR_4K_SPLIT_EN
        room = FourkBeats - 32'(addr_q % LITEWIDTH'(FourkBeats));
        if (room < cap) cap = room;
`endif
        len_next = (32'(remaining_q) < cap) ? 9'(remaining_q) : 9'(cap);
    end

    feature_row_fifo #(
        .WIDTH (W_WIDTH)
    ) u_row_fifo (
        .clk       (I_clk),
        .rst       (I_rst),
        .push      (row_push),
        .push_data (I_row_hindex),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q      <= StIdle;
            ap_q         <= 1'b0;
            ap_prev_q    <= 1'b0;
            base_q       <= '0;
            addr_q       <= '0;
            oheight_q    <= '0;
            hindex_q     <= '0;
            row_cnt_q    <= '0;
            line_beats_q <= '0;
            remaining_q  <= '0;
            len_q        <= '0;
            wr_len_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            ap_q      <= I_ap_start;
            ap_prev_q <= ap_q;
            done_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q       <= I_feature_out_base_addr;
                        line_beats_q <= LbW'(I_coMemGroup) * LbW'(I_owidth);
                        oheight_q    <= I_oheight;
                        row_cnt_q    <= '0;
                        if (I_oheight == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (!fifo_empty) begin
                        hindex_q <= fifo_data;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    if (hindex_q >= oheight_q) begin
                        state_q <= StWait;
                    end else if (line_beats_q != '0) begin
                        addr_q      <= base_q + LITEWIDTH'(hindex_q) * LITEWIDTH'(line_beats_q);
                        remaining_q <= line_beats_q;
                        state_q     <= StLen;
                    end
                end
                StLen: begin
                    len_q    <= len_next;
                    wr_len_q <= LenW'(len_next - 9'd1);
                    valid_q  <= 1'b1;
                    state_q  <= StIssue;
                end
                StIssue: begin
                    if (burst_hs) begin
                        valid_q     <= 1'b0;
                        addr_q      <= addr_q + LITEWIDTH'(len_q);
                        remaining_q <= remaining_q - LbW'(len_q);
                        state_q     <= StLen;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (row_fin) begin
                row_cnt_q <= row_cnt_q + {{(W_WIDTH-1){1'b0}}, 1'b1};
                if (row_last) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end else begin
                    state_q <= StWait;
                end
            end
        end
    end

    assign O_dram_feature_wr_addr  = addr_q;
    assign O_dram_feature_wr_len   = wr_len_q;
    assign O_dram_feature_wr_valid = valid_q;
    assign O_busy                  = busy_q;
    assign O_done                  = done_q;

endmodule

// File: tb/tb_dram_feature_wr_addr.sv
// Directed bench: base 0x1000, 2 groups x 40 pixels = 80 beats per row, MAX_BURST 64.
module tb_dram_feature_wr_addr;

    logic        I_clk = 1'b0;
    logic        I_rst;
    logic        I_ap_start;
    logic [31:0] I_feature_out_base_addr;
    logic [8:0]  I_coMemGroup;
    logic [9:0]  I_owidth;
    logic [9:0]  I_oheight;
    logic        I_row_valid;
    logic [9:0]  I_row_hindex;
    logic        O_row_rdy;
    logic [31:0] O_dram_feature_wr_addr;
    logic [7:0]  O_dram_feature_wr_len;
    logic        O_dram_feature_wr_valid;
    logic        I_dram_feature_wr_rdy;
    logic        O_busy;
    logic        O_done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int lat;

`ifdef DRAM_FEATURE_WR_4K_SPLIT_EN
    localparam logic [31:0] T1Len0  = 32'd15;
    localparam logic [31:0] T1Addr1 = 32'h1100;
    localparam logic [31:0] T1Len1  = 32'd63;
`else
    localparam logic [31:0] T1Len0  = 32'd63;
    localparam logic [31:0] T1Addr1 = 32'h1130;
    localparam logic [31:0] T1Len1  = 32'd15;
`endif

    dram_feature_wr_addr dut (
        .I_clk                   (I_clk),
        .I_rst                   (I_rst),
        .I_ap_start              (I_ap_start),
        .I_feature_out_base_addr (I_feature_out_base_addr),
        .I_coMemGroup            (I_coMemGroup),
        .I_owidth                (I_owidth),
        .I_oheight               (I_oheight),
        .I_row_valid             (I_row_valid),
        .I_row_hindex            (I_row_hindex),
        .O_row_rdy               (O_row_rdy),
        .O_dram_feature_wr_addr  (O_dram_feature_wr_addr),
        .O_dram_feature_wr_len   (O_dram_feature_wr_len),
        .O_dram_feature_wr_valid (O_dram_feature_wr_valid),
        .I_dram_feature_wr_rdy   (I_dram_feature_wr_rdy),
        .O_busy                  (O_busy),
        .O_done                  (O_done)
    );

    always #5 I_clk = ~I_clk;

    always @(posedge I_clk) if (O_done) done_cnt++;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge I_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg();
        I_feature_out_base_addr = 32'h1000;
        I_coMemGroup            = 9'd2;
        I_owidth                = 10'd40;
    endtask

    task automatic start_layer(input logic [9:0] oh);
        I_oheight  = oh;
        I_ap_start = 1'b1;
        step(2);
        chk("start_busy", {31'd0, O_busy}, {31'd0, oh != 10'd0});
        chk("start_done", {31'd0, O_done}, {31'd0, oh == 10'd0});
        I_ap_start = 1'b0;
        step(2);
    endtask

    task automatic push_row(input logic [9:0] h);
        int n = 0;
        while (!O_row_rdy && n < 20) begin
            step();
            n++;
        end
        chk("push_row_rdy", {31'd0, O_row_rdy}, 32'd1);
        I_row_valid  = 1'b1;
        I_row_hindex = h;
        step();
        I_row_valid  = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int l);
        l = 0;
        while (!O_dram_feature_wr_valid && l < 20) begin
            step();
            l++;
        end
        chk({tag, "_valid"}, {31'd0, O_dram_feature_wr_valid}, 32'd1);
    endtask

    task automatic wait_burst(input string tag, input logic [31:0] a, input logic [31:0] len,
                              output int l);
        wait_valid(tag, l);
        chk({tag, "_addr"}, O_dram_feature_wr_addr, a);
        chk({tag, "_len"}, {24'd0, O_dram_feature_wr_len}, len);
        if (O_dram_feature_wr_valid) step();
    endtask

    initial begin
        bit seen;
        I_rst = 1'b1;
        I_ap_start = 1'b0;
        I_oheight = 10'd4;
        I_row_valid = 1'b0;
        I_row_hindex = '0;
        I_dram_feature_wr_rdy = 1'b1;
        set_cfg();
        step(2);
        chk("rst_valid", {31'd0, O_dram_feature_wr_valid}, 32'd0);
        chk("rst_busy", {31'd0, O_busy}, 32'd0);
        chk("rst_done", {31'd0, O_done}, 32'd0);
        chk("rst_row_rdy", {31'd0, O_row_rdy}, 32'd0);
        chk("rst_addr", O_dram_feature_wr_addr, 32'd0);
        chk("rst_len", {24'd0, O_dram_feature_wr_len}, 32'd0);
        I_rst = 1'b0;
        step();

        // Row 3 of a 4-row layer: 80 beats from 0x10F0.
        start_layer(10'd4);
        push_row(10'd3);
        wait_burst("t1_b0", 32'h10F0, T1Len0, lat);
        chk("t1_latency", lat, 32'd3);
        wait_burst("t1_b1", T1Addr1, T1Len1, lat);
        chk("t1_gap", lat, 32'd1);
        chk("t1_busy", {31'd0, O_busy}, 32'd1);
        chk("t1_no_done", done_cnt, 32'd0);

        // Out-of-range row is consumed without a burst.
        push_row(10'd5);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen |= O_dram_feature_wr_valid;
            step();
        end
        chk("t4_no_burst", {31'd0, seen}, 32'd0);
        chk("t4_no_done", done_cnt, 32'd0);
        chk("t4_busy", {31'd0, O_busy}, 32'd1);

        // Second start edge while busy must not relatch config.
        I_feature_out_base_addr = 32'h5000;
        I_owidth = 10'd1;
        I_ap_start = 1'b1;
        step(3);
        I_ap_start = 1'b0;
        step(2);
        chk("t6_busy", {31'd0, O_busy}, 32'd1);
        push_row(10'd0);
        wait_burst("t6_b0", 32'h1000, 32'd63, lat);
        wait_burst("t6_b1", 32'h1040, 32'd15, lat);
        chk("t6_no_done", done_cnt, 32'd0);

        // Reset while a burst is waiting for rdy.
        set_cfg();
        I_dram_feature_wr_rdy = 1'b0;
        push_row(10'd1);
        wait_valid("t5_pre", lat);
        chk("t5_pre_addr", O_dram_feature_wr_addr, 32'h1050);
        I_rst = 1'b1;
        step();
        chk("t5_valid", {31'd0, O_dram_feature_wr_valid}, 32'd0);
        chk("t5_busy", {31'd0, O_busy}, 32'd0);
        chk("t5_row_rdy", {31'd0, O_row_rdy}, 32'd0);
        I_rst = 1'b0;
        I_dram_feature_wr_rdy = 1'b1;
        step();
        start_layer(10'd4);
        push_row(10'd2);
        wait_burst("t5_b0", 32'h10A0, 32'd63, lat);
        wait_burst("t5_b1", 32'h10E0, 32'd15, lat);

        // Zero-height layer completes at once.
        I_rst = 1'b1;
        step(2);
        I_rst = 1'b0;
        step();
        start_layer(10'd0);
        chk("h0_done_cnt", done_cnt, 32'd1);
        chk("h0_valid", {31'd0, O_dram_feature_wr_valid}, 32'd0);

        // Two-row layer with back-pressure and a dropped row in the queue.
        start_layer(10'd2);
        I_dram_feature_wr_rdy = 1'b0;
        push_row(10'd0);
        push_row(10'd7);
        push_row(10'd1);
        chk("t3_full_rdy", {31'd0, O_row_rdy}, 32'd0);
        wait_valid("t3_hold", lat);
        step(10);
        chk("t3_hold_valid", {31'd0, O_dram_feature_wr_valid}, 32'd1);
        chk("t3_hold_addr", O_dram_feature_wr_addr, 32'h1000);
        chk("t3_hold_len", {24'd0, O_dram_feature_wr_len}, 32'd63);
        chk("t3_hold_rdy", {31'd0, O_row_rdy}, 32'd0);
        I_dram_feature_wr_rdy = 1'b1;
        wait_burst("t3_r0b0", 32'h1000, 32'd63, lat);
        wait_burst("t3_r0b1", 32'h1040, 32'd15, lat);
        chk("t3_mid_done", done_cnt, 32'd1);
        wait_burst("t3_r1b0", 32'h1050, 32'd63, lat);
        wait_burst("t3_r1b1", 32'h1090, 32'd15, lat);
        chk("t3_done", {31'd0, O_done}, 32'd1);
        chk("t3_busy", {31'd0, O_busy}, 32'd0);
        step();
        chk("t3_done_off", {31'd0, O_done}, 32'd0);
        chk("t3_done_cnt", done_cnt, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
